multimode_time_counter: RTL and testbench

- Parametrised successor to the single-mode clock counter: one shared millisecond prescaler drives three independent time bases.
  - Time-of-day clock.
  - Stopwatch (count up).
  - Countdown timer with alarm.
- `mode` selects which time base drives the outputs; all three keep state in the background.
- Sits between the button/switch debouncers and the 7-segment display formatter.

---
 rtl/multimode_time_counter_pkg.sv | 7 +
 rtl/time_field_counter.sv | 21 ++
 rtl/multimode_time_counter.sv | 94 +++++++++
 tb/tb_multimode_time_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multimode_time_counter_pkg.sv
// multimode_time_pkg: mode/field encodings and time-field limits
package multimode_time_pkg;
  typedef enum logic [1:0] {MODE_CLK = 2'b00, MODE_SW = 2'b01, MODE_TMR = 2'b10, MODE_FRZ = 2'b11} mode_e;
  typedef enum logic [1:0] {FLD_SEC = 2'b00, FLD_MIN = 2'b01, FLD_HR = 2'b10} field_e;
  localparam int MS_MAX = 999;
  localparam int SM_MAX = 59;
endpackage

// File: rtl/time_field_counter.sv
// time_field_counter: one modulo-MOD digit group with carry/borrow out
module time_field_counter #(
  parameter int MOD = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         set_inc,
  input  logic         clear,
  output logic [W-1:0] value,
  output logic         cy
);
  localparam logic [W-1:0] TOP = W'(MOD - 1);
  assign cy = (inc && value == TOP) || (dec && value == '0);
  always_ff @(posedge clk)
    if (rst || clear) value <= '0;
    else if (set_inc || inc) value <= value == TOP ? '0 : value + 1'b1;
    else if (dec) value <= value == '0 ? TOP : value - 1'b1;
endmodule

// File: rtl/multimode_time_counter.sv
// multimode_time_counter: clock, stopwatch and countdown timer on a shared ms prescaler
module multimode_time_counter
  import multimode_time_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int HR_MAX_CLK = 24,
  parameter int HR_MAX_SW = 100
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic        run,
  input  logic        clear,
  input  logic        set_en,
  input  logic [1:0]  set_field,
  input  logic        set_inc,
  input  logic        hr12,
  output logic [11:0] milli_o,
  output logic [7:0]  seconds_o,
  output logic [7:0]  minutes_o,
  output logic [7:0]  hours_o,
  output logic        pm_o,
  output logic        sec_tick_o,
  output logic        alarm_o
);
  localparam int PW = $clog2(TICK_DIV + 1);
  logic [PW-1:0] pre;
  logic tick, set_act, tz, tone;
  logic [2:0] adv, en, clr, ss, sm, sh, unused_cy;
  logic [9:0] ms_v [3];
  logic [5:0] s_v [3];
  logic [5:0] m_v [3];
  logic [7:0] h_v [3];
  logic [9:0] d_ms;
  logic [5:0] d_s, d_m;
  logic [7:0] d_h, h12;
  logic d_pm;
  assign tick = pre == PW'(TICK_DIV - 1);
  always_ff @(posedge clk_in) pre <= (reset || tick) ? '0 : pre + 1'b1;
  assign set_act = set_en && set_inc;
  assign en = {mode == MODE_TMR && !run, 1'b0, mode == MODE_CLK};
  assign ss = en & {3{set_act && set_field == FLD_SEC}};
  assign sm = en & {3{set_act && set_field == FLD_MIN}};
  assign sh = en & {3{set_act && set_field == FLD_HR}};
  assign clr = {1'b0, clear && !run, 1'b0};
  assign tz = {ms_v[2], s_v[2], m_v[2], h_v[2]} == '0;
  assign tone = {s_v[2], m_v[2], h_v[2]} == '0 && ms_v[2] == 10'd1;
  assign adv = {tick && run && !tz, tick && run, tick && !(mode == MODE_CLK && set_en)};
  // base 0 = clock, 1 = stopwatch (both count up), 2 = timer (counts down)
  for (genvar b = 0; b < 3; b++) begin : g_base
    localparam bit DN = (b == 2);
    localparam int HM = (b == 0) ? HR_MAX_CLK : HR_MAX_SW;
    logic c1, c2, c3;
    time_field_counter #(.MOD(MS_MAX + 1), .W(10)) u_ms (
      .clk(clk_in), .rst(reset), .inc(!DN && adv[b]), .dec(DN && adv[b]),
      .set_inc(1'b0), .clear(clr[b] || ss[b]), .value(ms_v[b]), .cy(c1));
    time_field_counter #(.MOD(SM_MAX + 1), .W(6)) u_sec (
      .clk(clk_in), .rst(reset), .inc(!DN && c1), .dec(DN && c1),
      .set_inc(ss[b]), .clear(clr[b]), .value(s_v[b]), .cy(c2));
    time_field_counter #(.MOD(SM_MAX + 1), .W(6)) u_min (
      .clk(clk_in), .rst(reset), .inc(!DN && c2), .dec(DN && c2),
      .set_inc(sm[b]), .clear(clr[b]), .value(m_v[b]), .cy(c3));
    time_field_counter #(.MOD(HM), .W(8)) u_hr (
      .clk(clk_in), .rst(reset), .inc(!DN && c3), .dec(DN && c3),
      .set_inc(sh[b]), .clear(clr[b]), .value(h_v[b]), .cy(unused_cy[b]));
  end
  always_ff @(posedge clk_in) sec_tick_o <= !reset && adv[0] && ms_v[0] == 10'(MS_MAX);
  always_ff @(posedge clk_in)
    if (reset || !run || ss[2] || sm[2] || sh[2]) alarm_o <= 1'b0;
    else if (tz || (adv[2] && tone)) alarm_o <= 1'b1;
  always_comb begin
    d_ms = mode == MODE_SW ? ms_v[1] : mode == MODE_TMR ? ms_v[2] : ms_v[0];
    d_s = mode == MODE_SW ? s_v[1] : mode == MODE_TMR ? s_v[2] : s_v[0];
    d_m = mode == MODE_SW ? m_v[1] : mode == MODE_TMR ? m_v[2] : m_v[0];
    h12 = h_v[0] == 8'd0 ? 8'd12 : h_v[0] > 8'd12 ? h_v[0] - 8'd12 : h_v[0];
    d_h = mode == MODE_SW ? h_v[1] : mode == MODE_TMR ? h_v[2] : hr12 ? h12 : h_v[0];
    d_pm = mode == MODE_CLK && hr12 && h_v[0] >= 8'd12;
  end
  // freeze simply stops updating, so the output registers are the snapshot
  always_ff @(posedge clk_in)
    if (reset) begin
      milli_o <= '0;
      seconds_o <= '0;
      minutes_o <= '0;
      hours_o <= '0;
      pm_o <= 1'b0;
    end else if (mode != MODE_FRZ) begin
      milli_o <= {2'b00, d_ms};
      seconds_o <= {2'b00, d_s};
      minutes_o <= {2'b00, d_m};
      hours_o <= d_h;
      pm_o <= d_pm;
    end
endmodule

// File: tb/tb_multimode_time_counter.sv
// tb_multimode_time_counter: directed checks of all three time bases with TICK_DIV=2
module tb_multimode_time_counter;
  import multimode_time_pkg::*;
  logic clk_in = 0, reset = 1, run = 0, clear = 0, set_en = 0, set_inc = 0, hr12 = 0;
  logic [1:0] mode = 2'b00, set_field = 2'b00;
  logic [11:0] milli_o;
  logic [7:0] seconds_o, minutes_o, hours_o;
  logic pm_o, sec_tick_o, alarm_o;
  int n_chk = 0, n_fail = 0, ticks = 0;
  always #5 clk_in = ~clk_in;
  multimode_time_counter #(.TICK_DIV(2), .HR_MAX_CLK(24), .HR_MAX_SW(100)) dut (
    .clk_in(clk_in), .reset(reset), .mode(mode), .run(run), .clear(clear),
    .set_en(set_en), .set_field(set_field), .set_inc(set_inc), .hr12(hr12),
    .milli_o(milli_o), .seconds_o(seconds_o), .minutes_o(minutes_o), .hours_o(hours_o),
    .pm_o(pm_o), .sec_tick_o(sec_tick_o), .alarm_o(alarm_o));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask
  task automatic run_ms(input int n);
    step(2 * n);
  endtask
  task automatic rst_pulse();
    reset = 1;
    step(2);
    reset = 0;
  endtask
  task automatic pulses(input logic [1:0] f, input int n);
    set_field = f;
    repeat (n) begin
      set_inc = 1;
      step(1);
      set_inc = 0;
      step(1);
    end
  endtask
  task automatic check_time(input string tag, input int h, input int m, input int s, input int ms);
    check({tag, "_hr"}, 32'(hours_o), h);
    check({tag, "_min"}, 32'(minutes_o), m);
    check({tag, "_sec"}, 32'(seconds_o), s);
    check({tag, "_ms"}, 32'(milli_o), ms);
  endtask
  task automatic check_zero(input string tag);
    check_time(tag, 0, 0, 0, 0);
    check({tag, "_pm"}, 32'(pm_o), 0);
    check({tag, "_stick"}, 32'(sec_tick_o), 0);
    check({tag, "_alarm"}, 32'(alarm_o), 0);
  endtask
  task automatic clock_set();
    rst_pulse();
    mode = MODE_CLK;
    set_en = 1;
    pulses(FLD_HR, 23);
    pulses(FLD_MIN, 59);
    pulses(FLD_SEC, 59);
  endtask
  initial begin
    step(2);
    check_zero("reset");
    reset = 0;
    for (int i = 0; i < 6001; i++) begin
      step(1);
      ticks += int'(sec_tick_o);
    end
    check_time("clk3s", 0, 0, 3, 0);
    check("clk3s_pulses", ticks, 3);
    clock_set();
    check_time("set24", 23, 59, 59, 0);
    set_en = 0;
    step(1);
    run_ms(1000);
    check_time("midnight", 0, 0, 0, 0);
    hr12 = 1;
    clock_set();
    check("set12_hr", 32'(hours_o), 11);
    check("set12_pm", 32'(pm_o), 1);
    set_en = 0;
    step(1);
    run_ms(1000);
    check("wrap12_hr", 32'(hours_o), 12);
    check("wrap12_pm", 32'(pm_o), 0);
    hr12 = 0;
    rst_pulse();
    mode = MODE_SW;
    run = 1;
    run_ms(1500);
    run = 0;
    step(2);
    check_time("sw1500", 0, 0, 1, 500);
    run_ms(100);
    check_time("sw_hold", 0, 0, 1, 500);
    clear = 1;
    step(1);
    clear = 0;
    step(1);
    check_time("sw_clear", 0, 0, 0, 0);
    run = 1;
    run_ms(100);
    clear = 1;
    step(1);
    clear = 0;
    step(1);
    run_ms(149);
    run = 0;
    step(2);
    check_time("sw_clr_run", 0, 0, 0, 250);
    set_en = 1;
    pulses(FLD_SEC, 3);
    set_en = 0;
    check_time("sw_noset", 0, 0, 0, 250);
    rst_pulse();
    mode = MODE_TMR;
    set_en = 1;
    pulses(FLD_SEC, 2);
    set_en = 0;
    check_time("tmr_set", 0, 0, 2, 0);
    check("tmr_set_alarm", 32'(alarm_o), 0);
    run = 1;
    run_ms(1999);
    step(1);
    check("tmr_1ms_ms", 32'(milli_o), 1);
    check("tmr_1ms_alarm", 32'(alarm_o), 0);
    step(1);
    check("tmr_zero_alarm", 32'(alarm_o), 1);
    step(1);
    check_time("tmr_zero", 0, 0, 0, 0);
    run_ms(10);
    check_time("tmr_stop", 0, 0, 0, 0);
    check("tmr_stop_alarm", 32'(alarm_o), 1);
    run = 0;
    step(2);
    check("tmr_runlow_alarm", 32'(alarm_o), 0);
    run = 1;
    step(1);
    check("tmr_start0_alarm", 32'(alarm_o), 1);
    run = 0;
    step(1);
    rst_pulse();
    mode = MODE_CLK;
    run_ms(5000);
    step(1);
    check_time("frz_pre", 0, 0, 5, 0);
    mode = MODE_FRZ;
    run_ms(2000);
    check_time("frz_hold", 0, 0, 5, 0);
    mode = MODE_CLK;
    step(1);
    check_time("frz_back", 0, 0, 7, 0);
    rst_pulse();
    mode = MODE_TMR;
    set_en = 1;
    pulses(FLD_SEC, 2);
    set_en = 0;
    run = 1;
    run_ms(300);
    check("mid_pre_sec", 32'(seconds_o), 1);
    reset = 1;
    step(1);
    check_zero("mid_reset");
    run = 0;
    mode = MODE_CLK;
    reset = 0;
    step(2);
    check("first_tick_pre", 32'(milli_o), 0);
    step(1);
    check("first_tick", 32'(milli_o), 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
